// File: rtl/key_debouncer_pkg.sv
// Shared types, default timing constants and width helpers for the KEY debouncer.
package key_debouncer_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_MS         = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_PERIOD = 2'd2
  } rep_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: synchronizer, debounce counter, press/release strobes and, with
// KEY_DEBOUNCER_AUTOREPEAT_EN defined, an auto-repeat FSM.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   raw_c, accept_press_c, accept_release_c, rep_fire_c;

  // Synchronize, then accept a new level only after it persists for the full window.
  always_comb begin : debounce
    sync_d           = {sync_q[SYNC_STAGES-2:0], key_n_i};
    raw_c            = ~sync_q[SYNC_STAGES-1];
    cnt_d            = '0;
    stable_d         = stable_q;
    accept_press_c   = 1'b0;
    accept_release_c = 1'b0;
    if (raw_c != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d         = raw_c;
        accept_press_c   = raw_c;
        accept_release_c = ~raw_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin : pulses
    press_d   = accept_press_c | rep_fire_c;
    release_d = accept_release_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int unsigned REP_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  rep_state_t       rep_state_q, rep_state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_state_q <= REP_IDLE;
      rep_cnt_q   <= '0;
    end else begin
      rep_state_q <= rep_state_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  // A release overrides everything, so no repeat strobe lands on the release cycle.
  always_comb begin : repeat_fsm
    rep_state_d = rep_state_q;
    rep_cnt_d   = rep_cnt_q;
    rep_fire_c  = 1'b0;
    if (accept_release_c) begin
      rep_state_d = REP_IDLE;
      rep_cnt_d   = '0;
    end else begin
      case (rep_state_q)
        REP_IDLE: begin
          if (accept_press_c) begin
            rep_state_d = REP_DELAY;
            rep_cnt_d   = '0;
          end
        end
        REP_DELAY: begin
          if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
            rep_fire_c  = 1'b1;
            rep_state_d = REP_PERIOD;
            rep_cnt_d   = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        REP_PERIOD: begin
          if (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
            rep_fire_c = 1'b1;
            rep_cnt_d  = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        default: begin
          rep_state_d = REP_IDLE;
          rep_cnt_d   = '0;
        end
      endcase
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire_c        = 1'b0;
`endif

  assign pressed_o       = stable_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces the active-low board KEYs into clean levels and press/release strobes.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press strobes.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i          (CLOCK_50),
      .rst_ni         (reset_n),
      .key_n_i        (key_n[k]),
      .pressed_o      (pressed[k]),
      .press_pulse_o  (press_pulse[k]),
      .release_pulse_o(release_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: vector table, hand sequences and random
// stimulus against a window-based reference model.
module tb_key_debouncer;

  localparam int NK   = 4;
  localparam int SS   = 2;
  localparam int DC   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int HIST = 2048;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] pressed, pp, rp;

  always #5 clk = ~clk;

  key_debouncer #(
    .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .key_n(key_n),
    .pressed(pressed), .press_pulse(pp), .release_pulse(rp)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Reference model: raw history per key, level flips after DC consecutive
  // differing raw samples since the last flip or reset.
  bit            m_dl     [NK][SS];
  bit            raw_hist [NK][HIST];
  int            last_evt [NK];
  int            t_press  [NK];
  logic [NK-1:0] e_p, e_pp, e_rp;

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      for (int s = 0; s < SS; s++) m_dl[i][s] = 1'b1;
      last_evt[i] = cyc;
      t_press[i]  = cyc;
    end
    e_p = '0; e_pp = '0; e_rp = '0;
  endtask

  task automatic model_step();
    bit raw;
    bit flip;
    int age;
    cyc++;
    if (cyc >= HIST) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, HIST);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    e_pp = '0; e_rp = '0;
    for (int i = 0; i < NK; i++) begin
      raw = ~m_dl[i][0];
      for (int s = 0; s < SS - 1; s++) m_dl[i][s] = m_dl[i][s+1];
      m_dl[i][SS-1] = key_n[i];
      raw_hist[i][cyc] = raw;
      flip = (cyc - last_evt[i]) >= DC;
      if (flip)
        for (int k = 0; k < DC; k++)
          if (raw_hist[i][cyc-k] == e_p[i]) flip = 1'b0;
      if (flip) begin
        e_p[i]      = ~e_p[i];
        last_evt[i] = cyc;
        if (e_p[i]) begin
          e_pp[i]    = 1'b1;
          t_press[i] = cyc;
        end else begin
          e_rp[i] = 1'b1;
        end
      end else begin
        age = cyc - t_press[i];
        if (REP_EN && e_p[i] && age >= RD && ((age - RD) % RP) == 0) e_pp[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("model", {pressed, pp, rp}, {e_p, e_pp, e_rp});
  endtask

  typedef struct {
    logic [NK-1:0] key_n;
    int            n;
    logic [NK-1:0] p, pp, rp;
  } vec_t;

  vec_t tbl [16];

  function automatic bit exp_rep(input int j, input int rel);
    return (j == DC + SS) ||
           (REP_EN && j >= DC + SS + RD && j < rel && ((j - (DC + SS + RD)) % RP) == 0);
  endfunction

  task automatic repeat_seq(input string nm, input int hold);
    int cnt;
    int exp_cnt;
    cnt = 0; exp_cnt = 0;
    key_n = 4'b0111;
    for (int j = 1; j <= hold + DC + SS + 4; j++) begin
      if (j == hold + 1) key_n = 4'b1111;
      tick();
      check($sformatf("%s_pulse%0d", nm, j), 12'(pp[3]), 12'(exp_rep(j, hold + DC + SS)));
      cnt += int'(pp[3]);
      exp_cnt += int'(exp_rep(j, hold + DC + SS));
    end
    check($sformatf("%s_count", nm), 12'(cnt), 12'(exp_cnt));
    check($sformatf("%s_released", nm), 12'(pressed), 12'(0));
  endtask

  initial begin
    tbl[0]  = '{4'b1110, 5, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1110, 1, 4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b1110, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1111, 5, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1101, 3, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1101, 3, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1111, 8, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0000, 5, 4'b0000, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0000, 1, 4'b1111, 4'b1111, 4'b0000};
    tbl[12] = '{4'b0000, 1, 4'b1111, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1111, 5, 4'b1111, 4'b0000, 4'b0000};
    tbl[14] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b1111};
    tbl[15] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000};

    rst_n = 1'b0;
    key_n = 4'b1111;
    model_reset();
    #1;
    check("reset_state", {pressed, pp, rp}, 12'h000);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Clean press, release, bounce and simultaneous keys
    foreach (tbl[r]) begin
      key_n = tbl[r].key_n;
      for (int c = 0; c < tbl[r].n; c++) tick();
      check($sformatf("table_row%0d", r), {pressed, pp, rp}, {tbl[r].p, tbl[r].pp, tbl[r].rp});
    end

    // Reset asserted mid-count with a key held through it
    key_n = 4'b1110;
    for (int i = 0; i < 7; i++) tick();
    check("pre_reset_pressed", 12'(pressed), 12'(4'b0001));
    key_n = 4'b1010;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_clears", {pressed, pp, rp}, 12'h000);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("held_through_reset_early", {pressed, pp, rp}, 12'h000);
    tick();
    check("held_through_reset_accept", {pressed, pp, rp}, {4'b0101, 4'b0101, 4'b0000});
    key_n = 4'b1111;
    for (int i = 0; i < 8; i++) tick();

    // Long hold on key 3 (release lands on a would-be repeat), then a re-press
    repeat_seq("hold_long", 31);
    repeat_seq("repress", 17);

    // Random per-key toggling against the model
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 5) == 0) key_n[k] = ~key_n[k];
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
